// File: rtl/pifo_io_responder_if.sv
// IO port link between the port mux (master) and the PIFO responder (slave).
// Carries one push and one pop request per cycle plus the pop response and status.
interface pifo_io_responder_if #(
    parameter int unsigned PTW      = 16,
    parameter int unsigned MTW      = 32,
    parameter int unsigned PLW      = 12,
    parameter int unsigned TREE_NUM = 2
) ();
    localparam int unsigned DW  = MTW + PTW + PLW;
    localparam int unsigned TNB = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1;

    logic                i_push;
    logic [TNB-1:0]      i_push_tree_id;
    logic [DW-1:0]       i_push_data;
    logic                i_pop;
    logic [TNB-1:0]      i_pop_tree_id;
    logic                o_pop_valid;
    logic [TNB-1:0]      o_pop_tree_id;
    logic [DW-1:0]       o_pop_data;
    logic                o_is_level0_pop;
    logic [TREE_NUM-1:0] o_tree_full;
    logic                o_task_fifo_full;
    logic                o_push_drop;
    logic                o_pop_empty;

    modport master (
        output i_push, i_push_tree_id, i_push_data, i_pop, i_pop_tree_id,
        input  o_pop_valid, o_pop_tree_id, o_pop_data, o_is_level0_pop,
        input  o_tree_full, o_task_fifo_full, o_push_drop, o_pop_empty
    );

    modport slave (
        input  i_push, i_push_tree_id, i_push_data, i_pop, i_pop_tree_id,
        output o_pop_valid, o_pop_tree_id, o_pop_data, o_is_level0_pop,
        output o_tree_full, o_task_fifo_full, o_push_drop, o_pop_empty
    );
endinterface

// File: rtl/pifo_io_responder.sv
// PIFO end of the IO port link: one shift-register PIFO per tree, lowest priority popped first.
// All outputs are registered; a push and a pop may hit the same tree in one cycle.
module pifo_io_responder #(
    parameter int unsigned PTW       = 16,
    parameter int unsigned MTW       = 32,
    parameter int unsigned PLW       = 12,
    parameter int unsigned TREE_NUM  = 2,
    parameter int unsigned FIFO_SIZE = 8
) (
    input logic                 i_clk,
    input logic                 i_arst_n,
    pifo_io_responder_if.slave  bus
);
    localparam int unsigned DW   = MTW + PTW + PLW;
    localparam int unsigned TNB  = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1;
    localparam int unsigned CNTW = $clog2(FIFO_SIZE + 1);

    typedef logic [DW-1:0] entry_t;

    entry_t              r_entry   [TREE_NUM][FIFO_SIZE];
    logic [CNTW-1:0]     r_count   [TREE_NUM];
    logic                r_pop_valid;
    logic [TNB-1:0]      r_pop_tree_id;
    entry_t              r_pop_data;
    logic                r_is_level0;
    logic [TREE_NUM-1:0] r_tree_full;
    logic                r_task_full;
    logic                r_push_drop;
    logic                r_pop_empty;

    entry_t              w_entry_d [TREE_NUM][FIFO_SIZE];
    logic [CNTW-1:0]     w_count_d [TREE_NUM];
    entry_t              w_post    [FIFO_SIZE];
    logic [FIFO_SIZE-1:0] w_keep;
    logic [CNTW-1:0]     w_cnt_post;
    logic [TREE_NUM-1:0] w_pop_hit;
    logic [TREE_NUM-1:0] w_push_hit;
    logic [TREE_NUM-1:0] w_full_d;
    logic                w_push_ok;
    logic                w_pop_ok;
    logic [PTW-1:0]      w_new_prio;
    entry_t              w_pop_head;

    always_comb begin
        w_entry_d  = r_entry;
        w_count_d  = r_count;
        w_post     = r_entry[0];
        w_keep     = '0;
        w_cnt_post = '0;
        w_pop_hit  = '0;
        w_push_hit = '0;
        w_full_d   = '0;
        w_pop_head = '0;
        w_push_ok  = bus.i_push && (32'(bus.i_push_tree_id) < TREE_NUM);
        w_pop_ok   = bus.i_pop && (32'(bus.i_pop_tree_id) < TREE_NUM);
        w_new_prio = bus.i_push_data[PLW+:PTW];

        for (int unsigned t = 0; t < TREE_NUM; t++) begin
            w_pop_hit[t]  = w_pop_ok && (32'(bus.i_pop_tree_id) == t) && (r_count[t] != '0);
            // A full tree still takes the push when the same cycle pops it.
            w_push_hit[t] = w_push_ok && (32'(bus.i_push_tree_id) == t) &&
                            ((32'(r_count[t]) < FIFO_SIZE) || w_pop_hit[t]);
            w_cnt_post    = r_count[t] - CNTW'(w_pop_hit[t]);

            for (int unsigned i = 0; i < FIFO_SIZE - 1; i++) begin
                w_post[i] = w_pop_hit[t] ? r_entry[t][i+1] : r_entry[t][i];
            end
            w_post[FIFO_SIZE-1] = w_pop_hit[t] ? '0 : r_entry[t][FIFO_SIZE-1];

            // Keep-mask is a prefix: valid entries with prio <= new stay put (FIFO on ties).
            for (int unsigned i = 0; i < FIFO_SIZE; i++) begin
                w_keep[i] = (CNTW'(i) < w_cnt_post) && !(w_post[i][PLW+:PTW] > w_new_prio);
            end

            w_entry_d[t][0] = (!w_push_hit[t] || w_keep[0]) ? w_post[0] : bus.i_push_data;
            for (int unsigned i = 1; i < FIFO_SIZE; i++) begin
                if (!w_push_hit[t] || w_keep[i]) begin
                    w_entry_d[t][i] = w_post[i];
                end else if (w_keep[i-1]) begin
                    w_entry_d[t][i] = bus.i_push_data;
                end else begin
                    w_entry_d[t][i] = w_post[i-1];
                end
            end

            w_count_d[t] = r_count[t] - CNTW'(w_pop_hit[t]) + CNTW'(w_push_hit[t]);
            w_full_d[t]  = (32'(w_count_d[t]) == FIFO_SIZE);
            if (w_pop_hit[t]) begin
                w_pop_head = r_entry[t][0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            for (int unsigned t = 0; t < TREE_NUM; t++) begin
                r_count[t] <= '0;
                for (int unsigned i = 0; i < FIFO_SIZE; i++) begin
                    r_entry[t][i] <= '0;
                end
            end
            r_pop_valid   <= 1'b0;
            r_pop_tree_id <= '0;
            r_pop_data    <= '0;
            r_is_level0   <= 1'b0;
            r_tree_full   <= '0;
            r_task_full   <= 1'b0;
            r_push_drop   <= 1'b0;
            r_pop_empty   <= 1'b0;
        end else begin
            r_entry     <= w_entry_d;
            r_count     <= w_count_d;
            r_pop_valid <= |w_pop_hit;
            r_is_level0 <= (|w_pop_hit) && (bus.i_pop_tree_id == '0);
            if (|w_pop_hit) begin
                r_pop_tree_id <= bus.i_pop_tree_id;
                r_pop_data    <= w_pop_head;
            end
            r_tree_full <= w_full_d;
            r_task_full <= |w_full_d;
            r_push_drop <= bus.i_push && !(|w_push_hit);
            r_pop_empty <= bus.i_pop && !(|w_pop_hit);
        end
    end

    assign bus.o_pop_valid      = r_pop_valid;
    assign bus.o_pop_tree_id    = r_pop_tree_id;
    assign bus.o_pop_data       = r_pop_data;
    assign bus.o_is_level0_pop  = r_is_level0;
    assign bus.o_tree_full      = r_tree_full;
    assign bus.o_task_fifo_full = r_task_full;
    assign bus.o_push_drop      = r_push_drop;
    assign bus.o_pop_empty      = r_pop_empty;
endmodule

// File: tb/tb_pifo_io_responder.sv
// Directed bench for pifo_io_responder: ordering, full/drop, simultaneous push/pop, empty pops.
module tb_pifo_io_responder;
    localparam int unsigned PTW = 16, MTW = 32, PLW = 12, TREE_NUM = 2, FIFO_SIZE = 8;
    localparam int unsigned DW  = MTW + PTW + PLW;

    logic i_clk = 1'b0;
    logic i_arst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 i_clk = ~i_clk;

    pifo_io_responder_if #(.PTW(PTW), .MTW(MTW), .PLW(PLW), .TREE_NUM(TREE_NUM)) bus ();

    pifo_io_responder #(
        .PTW(PTW), .MTW(MTW), .PLW(PLW), .TREE_NUM(TREE_NUM), .FIFO_SIZE(FIFO_SIZE)
    ) dut (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .bus      (bus)
    );

    function automatic logic [DW-1:0] mk(input logic [31:0] meta, input logic [15:0] prio,
                                         input logic [11:0] len);
        return {meta, prio, len};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.i_push = 1'b0;
        bus.i_pop  = 1'b0;
    endtask

    task automatic push(input logic tree, input logic [DW-1:0] data);
        bus.i_push         = 1'b1;
        bus.i_push_tree_id = tree;
        bus.i_push_data    = data;
    endtask

    task automatic pop(input logic tree);
        bus.i_pop         = 1'b1;
        bus.i_pop_tree_id = tree;
    endtask

    task automatic chk_resp(input string tag, input logic tree, input logic [DW-1:0] data);
        chk({tag, ".valid"}, 64'(bus.o_pop_valid), 64'd1);
        chk({tag, ".tree"}, 64'(bus.o_pop_tree_id), 64'(tree));
        chk({tag, ".data"}, 64'(bus.o_pop_data), 64'(data));
        chk({tag, ".lvl0"}, 64'(bus.o_is_level0_pop), 64'(tree == 1'b0));
        chk({tag, ".empty"}, 64'(bus.o_pop_empty), 64'd0);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".valid"}, 64'(bus.o_pop_valid), 64'd0);
        chk({tag, ".empty"}, 64'(bus.o_pop_empty), 64'd1);
        chk({tag, ".lvl0"}, 64'(bus.o_is_level0_pop), 64'd0);
    endtask

    initial begin
        logic [2:0] perm [8];
        perm = '{3'd6, 3'd1, 3'd7, 3'd3, 3'd0, 3'd5, 3'd2, 3'd4};
        bus.i_push_tree_id = 1'b0;
        bus.i_pop_tree_id  = 1'b0;
        bus.i_push_data    = '0;
        idle();

        // T1: reset held with push active
        i_arst_n = 1'b0;
        push(1'b0, mk(32'hdead, 16'd1, 12'd1));
        tick(); tick(); tick();
        chk("rst.valid", 64'(bus.o_pop_valid), 64'd0);
        chk("rst.tree", 64'(bus.o_pop_tree_id), 64'd0);
        chk("rst.data", 64'(bus.o_pop_data), 64'd0);
        chk("rst.lvl0", 64'(bus.o_is_level0_pop), 64'd0);
        chk("rst.full", 64'(bus.o_tree_full), 64'd0);
        chk("rst.tfull", 64'(bus.o_task_fifo_full), 64'd0);
        chk("rst.drop", 64'(bus.o_push_drop), 64'd0);
        chk("rst.empty", 64'(bus.o_pop_empty), 64'd0);
        i_arst_n = 1'b1;
        idle();
        pop(1'b0);
        tick();
        chk_empty("rst.pop0");
        idle();

        // T2: ordering on tree1, equal prios stay FIFO
        push(1'b1, mk(32'h1, 16'd5, 12'd1)); tick();
        push(1'b1, mk(32'hA, 16'd2, 12'd2)); tick();
        push(1'b1, mk(32'h3, 16'd9, 12'd3)); tick();
        push(1'b1, mk(32'hB, 16'd2, 12'd4)); tick();
        idle();
        pop(1'b1); tick(); chk_resp("ord0", 1'b1, mk(32'hA, 16'd2, 12'd2));
        tick(); chk_resp("ord1", 1'b1, mk(32'hB, 16'd2, 12'd4));
        tick(); chk_resp("ord2", 1'b1, mk(32'h1, 16'd5, 12'd1));
        tick(); chk_resp("ord3", 1'b1, mk(32'h3, 16'd9, 12'd3));
        tick(); chk_empty("ord4");
        idle();

        // T3: fill tree0 in descending priority, then overflow
        for (int i = 0; i < 8; i++) begin
            push(1'b0, mk(32'h50 + 32'(i), 16'(10 - i), 12'd0));
            tick();
        end
        idle();
        chk("full.flags", 64'(bus.o_tree_full), 64'b01);
        chk("full.tfull", 64'(bus.o_task_fifo_full), 64'd1);
        chk("full.nodrop", 64'(bus.o_push_drop), 64'd0);
        push(1'b0, mk(32'h99, 16'd50, 12'd0)); tick(); idle();
        chk("drop.pulse", 64'(bus.o_push_drop), 64'd1);
        chk("drop.full", 64'(bus.o_tree_full), 64'b01);
        tick();
        chk("drop.clear", 64'(bus.o_push_drop), 64'd0);

        // T4: full tree0, push prio 1 and pop in the same cycle
        push(1'b0, mk(32'h44, 16'd1, 12'd7));
        pop(1'b0);
        tick(); idle();
        chk_resp("sim0", 1'b0, mk(32'h57, 16'd3, 12'd0));
        chk("sim0.drop", 64'(bus.o_push_drop), 64'd0);
        chk("sim0.full", 64'(bus.o_tree_full), 64'b01);
        pop(1'b0); tick(); idle();
        chk_resp("sim1", 1'b0, mk(32'h44, 16'd1, 12'd7));
        chk("sim1.full", 64'(bus.o_tree_full), 64'b00);

        // T5: push tree1 while popping tree0
        push(1'b1, mk(32'h77, 16'd7, 12'd5));
        pop(1'b0);
        tick(); idle();
        chk_resp("diff0", 1'b0, mk(32'h56, 16'd4, 12'd0));
        pop(1'b1); tick(); idle();
        chk_resp("diff1", 1'b1, mk(32'h77, 16'd7, 12'd5));
        pop(1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_resp("drain0", 1'b0, mk(32'h55 - 32'(i), 16'(5 + i), 12'd0));
        end
        tick(); idle();
        chk_empty("drain0.end");

        // T6: empty pop of tree1 holds last response data
        pop(1'b1); tick(); idle();
        chk_empty("emp1");
        chk("emp1.hold", 64'(bus.o_pop_data), 64'(mk(32'h50, 16'd10, 12'd0)));

        // Empty tree1 popped and pushed together: pop empty, push lands
        push(1'b1, mk(32'h5, 16'd5, 12'd9));
        pop(1'b1);
        tick(); idle();
        chk_empty("emppush");
        chk("emppush.drop", 64'(bus.o_push_drop), 64'd0);
        pop(1'b1); tick(); idle();
        chk_resp("emppush.get", 1'b1, mk(32'h5, 16'd5, 12'd9));

        // Fill and drain tree1 twice
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                push(1'b1, mk(32'h100 + 32'(perm[i]), 16'(3 * perm[i] + r), 12'(r)));
                tick();
            end
            idle();
            chk("wrap.full", 64'(bus.o_tree_full), 64'b10);
            pop(1'b1);
            for (int k = 0; k < 8; k++) begin
                tick();
                chk_resp("wrap.pop", 1'b1, mk(32'h100 + 32'(k), 16'(3 * k + r), 12'(r)));
            end
            tick(); idle();
            chk_empty("wrap.end");
            chk("wrap.nfull", 64'(bus.o_tree_full), 64'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
